// File: rtl/main_mem_if.sv
// main_mem_if: control and address signals of the main-memory port
interface main_mem_if;
    logic        CS;
    logic        OE;
    logic        WE;
    logic [31:0] Addr;
    modport master (output CS, OE, WE, Addr);
    modport slave  (input CS, OE, WE, Addr);
endinterface

// File: rtl/main_mem.sv
// main_mem: byte-wide synchronous memory model on a shared tristate data bus;
// writes commit at the edge, reads return one clock later.
module main_mem #(
    parameter int DEPTH_BITS = 10
) (
    input  logic       clk,
    input  logic       reset,
    main_mem_if.slave  bus,
    inout  wire  [7:0] Data
);
    logic [7:0] mem [2**DEPTH_BITS] = '{default: 8'h00};
    logic [DEPTH_BITS-1:0] idx;
    logic       rd_en;
    logic       oe_d, oe_q;
    logic [7:0] rd_data_d, rd_data_q;
    logic       unused_hi;

    assign idx = bus.Addr[DEPTH_BITS-1:0];
    // Upper address bits alias onto the physical store
    assign unused_hi = ^bus.Addr[31:DEPTH_BITS];

    always_comb begin
        rd_en     = bus.CS & bus.OE & ~bus.WE;
        oe_d      = rd_en;
        rd_data_d = rd_en ? mem[idx] : rd_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oe_q      <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            oe_q      <= oe_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Contents survive reset; a write on an edge with reset high is dropped
    always_ff @(posedge clk) begin
        if (!reset && bus.CS && bus.WE)
            mem[idx] <= Data;
    end

    // Live gating releases the bus the moment the master turns it around
    assign Data = (oe_q & rd_en) ? rd_data_q : 8'hzz;
endmodule

// File: tb/tb_main_mem.sv
// tb_main_mem: directed scoreboard bench; a released bus reads 8'hFF via pullups
module tb_main_mem;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    main_mem_if bus();
    wire  [7:0] Data;
    logic [7:0] drv;
    logic       drv_en;
    assign Data = drv_en ? drv : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (Data[g]);
    end

    main_mem #(.DEPTH_BITS(10)) dut (.clk(clk), .reset(reset), .bus(bus), .Data(Data));

    localparam logic [7:0] REL = 8'hFF;
    logic [7:0] model [1024];
    logic [7:0] sb [$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        bus.CS = 1'b1; bus.WE = 1'b1; bus.OE = 1'b0; bus.Addr = a;
        drv = d; drv_en = 1'b1;
        edge1();
        model[a[9:0]] = d;
    endtask

    task automatic rd(input string tag, input logic [31:0] a);
        logic [7:0] e;
        bus.CS = 1'b1; bus.OE = 1'b1; bus.WE = 1'b0; bus.Addr = a;
        drv_en = 1'b0;
        sb.push_back(model[a[9:0]]);
        edge1();
        e = sb.pop_front();
        chk(tag, Data, e);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = 8'h00;
        bus.CS = 1'b0; bus.OE = 1'b0; bus.WE = 1'b0; bus.Addr = 32'h0;
        drv = 8'h00; drv_en = 1'b0;
        #3;
        chk("reset_bus", Data, REL);
        chk("reset_oe", {7'b0, dut.oe_q}, 8'h00);
        chk("reset_rd_data", dut.rd_data_q, 8'h00);
        #4 reset = 1'b0;

        rd("unwritten_0x10", 32'h10);

        wr(32'h1, 8'h05);
        wr(32'h2, 8'h76);
        wr(32'hFFFF_FFFF, 8'h76);
        bus.CS = 1'b1; bus.OE = 1'b1; bus.WE = 1'b0; bus.Addr = 32'h1; drv_en = 1'b0;
        #1 chk("w2r_release", Data, REL);
        rd("rd_addr1", 32'h1);
        rd("rd_addr2", 32'h2);
        rd("rd_ffffffff", 32'hFFFF_FFFF);
        rd("alias_3ff", 32'h3FF);

        bus.WE = 1'b1;
        #1 chk("r2w_release", Data, REL);
        wr(32'h0000_0400, 8'hA5);
        rd("alias_0", 32'h0);

        bus.CS = 1'b0;
        #1 chk("cs0_release", Data, REL);
        bus.WE = 1'b1;
        #1 chk("cs0_we_release", Data, REL);
        bus.WE = 1'b0;
        edge1();
        bus.CS = 1'b1;
        #1 chk("cs1_no_stale", Data, REL);

        rd("rd_addr1_pre_rst", 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rst_release", Data, REL);
        chk("rst_oe", {7'b0, dut.oe_q}, 8'h00);
        chk("rst_rd_data", dut.rd_data_q, 8'h00);
        bus.WE = 1'b1; bus.Addr = 32'h1; drv = 8'hEE; drv_en = 1'b1;
        edge1();
        reset = 1'b0;
        rd("rst_preserved", 32'h1);

        wr(32'h7, 8'h3C);
        rd("raw_addr7", 32'h7);

        wr(32'h10, 8'h11);
        wr(32'h11, 8'h22);
        rd("b2b_rd_0x10", 32'h10);
        rd("b2b_rd_0x11", 32'h11);
        rd("b2b_rd_addr7", 32'h7);

        bus.CS = 1'b0;
        #1 chk("final_release", Data, REL);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/main_mem.md
# main_mem

Byte-wide synchronous main-memory model with a bidirectional 8-bit data bus. It stands in for system main memory behind the processor's memory interface. Writes are clocked in from the shared `Data` bus, and reads are returned on the same bus one clock later. The block takes a 32-bit byte address and implements a parameterised physical store. Upper address bits alias onto that store.

## Interface
- `DEPTH_BITS`, default 10: log2 of storage size in bytes (default 1024 B). Physical index is `Addr[DEPTH_BITS-1:0]`.
- `clk` input, 1 bit: single system clock; all state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `CS` input, 1 bit: chip select; when low the block ignores all other inputs and releases `Data`.
- `OE` input, 1 bit: output (read) enable.
- `WE` input, 1 bit: write enable; has priority over `OE`.
- `Addr` input, 32 bits: byte address.
- `Data` inout, 8 bits: write data in, read data out; high-impedance when not driving.

## Operation
- Storage: 2^DEPTH_BITS bytes. All locations are 8'h00 at time zero (power-up initialisation). Reset does not alter contents.
- Address decode: only `Addr[DEPTH_BITS-1:0]` is used; upper bits are ignored. Addresses 32'hFFFFFFFF and 2^DEPTH_BITS-1 therefore reach the same byte.
- Write: at a rising edge with `CS=1` and `WE=1`, the block stores `Data` into mem[index]. `OE` is don't-care.
- Read: at a rising edge with `CS=1`, `OE=1`, `WE=0`:
  - register `rd_data <= mem[index]`;
  - register `oe_r <= 1`.
- Any other edge: `oe_r <= 0`; `rd_data` holds its value.
- Bus drive: `Data = rd_data` only when `oe_r & CS & OE & ~WE`; otherwise `Data` is 8'hZZ. The combinational gating guarantees the block releases the bus in the same cycle the master raises `WE` or drops `CS`/`OE`, so there is no contention.
- Read-after-write: a read issued in the cycle after a write to the same index returns the newly written byte.
- Idle (`CS=0`): no write, `oe_r` cleared at next edge, bus Z immediately.

## Timing
- Reset (async, any time): `oe_r=0` and `rd_data=8'h00` immediately; `Data` released to Z immediately.
  - A write on the edge coinciding with reset assertion is discarded.
  - Memory contents are untouched.
- Write latency: data is committed at the sampling edge.
- Read latency: 1 clock.
  - Inputs are set up before edge N, and `Data` is valid after edge N (plus clock-to-out).
  - The value holds until the next edge, as long as `CS`/`OE` remain high and `WE` low.
- Back-to-back reads at different addresses: one new byte per clock, each returned one edge after its address was sampled.
- Back-to-back writes: one byte per clock, no wait states.
- Read → write turnaround: `Data` goes Z combinationally when `WE` rises; the write is sampled at the next edge.
- Write → read turnaround: `Data` stays Z until the first read edge; it is driven after that edge.

## Test plan
- Write sequence:
  - at consecutive edges with CS=1, WE=1, drive Addr=1 with Data=8'h05, Addr=2 with 8'h76, Addr=32'hFFFFFFFF with 8'h76;
  - then read Addr 1, 2, 32'hFFFFFFFF on consecutive edges with OE=1, WE=0 and the bench bus released;
  - required: Data=8'h05, 8'h76, 8'h76, each valid one edge after its address.
- Aliasing: write 8'hA5 to Addr=32'h0000_0400 (DEPTH_BITS=10), then read Addr=0 → Data=8'hA5.
- Bus release:
  - with CS=0 (any OE/WE) → Data=Z;
  - in the cycle WE rises after a read → Data=Z with no X on the bus;
  - in the cycle after the write edge, the memory still does not drive.
- Reset mid-read:
  - after a read drives 8'h05, assert reset between edges → Data=Z immediately, oe_r=0;
  - deassert reset and read Addr=1 again → 8'h05 (contents preserved).
- Unwritten location: read Addr=32'h10 after power-up → Data=8'h00.
- Read-after-write same address: write 8'h3C to Addr=7, read Addr=7 on the very next edge → Data=8'h3C one edge later.
